// File: rtl/ifu_lsu_arbiter_if.sv
// Request/response bundle between the IFU, the LSU and the shared data-memory port.
// The arbiter connects through the slave view; the environment drives the master view.
interface ifu_lsu_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  logic        rsp_err;
  logic        bus_err;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output rsp_err, bus_err
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  rsp_err, bus_err
  );
endinterface

// File: rtl/ifu_lsu_arbiter.sv
// Shares one data-memory port between instruction fetch and load/store, one transaction
// in flight; LSU has priority, IFU is forced through after STARVE_LIMIT losses.
module ifu_lsu_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  ifu_lsu_arbiter_if.slave  bus
);
  localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]    state_q,   state_d;
  logic          owner_q,   owner_d;
  logic          wen_q,     wen_d;
  logic [31:0]   addr_q,    addr_d;
  logic [31:0]   wdata_q,   wdata_d;
  logic [3:0]    wmask_q,   wmask_d;
  logic [SW-1:0] streak_q,  streak_d;
  logic [TW-1:0] tmo_q,     tmo_d;
  logic          ifu_rsp_q, ifu_rsp_d;
  logic          lsu_rsp_q, lsu_rsp_d;
  logic [31:0]   rdata_q,   rdata_d;
  logic          err_q,     err_d;
  logic          bus_err_q, bus_err_d;

  logic grant_ifu;
  logic grant_lsu;

  // Grants are only offered in IDLE, including the cycle that carries the previous response.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || streak_q == STREAK_MAX);
      grant_lsu = bus.lsu_req_valid && !grant_ifu;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    streak_d  = streak_q;
    tmo_d     = tmo_q;
    ifu_rsp_d = 1'b0;
    lsu_rsp_d = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_ifu) begin
          owner_d  = OWN_IFU;
          wen_d    = 1'b0;
          addr_d   = bus.ifu_addr;
          wdata_d  = '0;
          wmask_d  = '0;
          streak_d = '0;
          state_d  = S_REQ;
        end else if (grant_lsu) begin
          owner_d  = OWN_LSU;
          wen_d    = bus.lsu_wen;
          addr_d   = bus.lsu_addr;
          wdata_d  = bus.lsu_wdata;
          wmask_d  = bus.lsu_wmask;
          state_d  = S_REQ;
          if (!bus.ifu_req_valid)          streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          rdata_d   = wen_q ? 32'd0 : bus.mem_rdata;
          ifu_rsp_d = (owner_q == OWN_IFU);
          lsu_rsp_d = (owner_q == OWN_LSU);
          state_d   = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d     = 1'b1;
          bus_err_d = 1'b1;
          ifu_rsp_d = (owner_q == OWN_IFU);
          lsu_rsp_d = (owner_q == OWN_LSU);
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IFU;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      streak_q  <= '0;
      tmo_q     <= '0;
      ifu_rsp_q <= 1'b0;
      lsu_rsp_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      streak_q  <= streak_d;
      tmo_q     <= tmo_d;
      ifu_rsp_q <= ifu_rsp_d;
      lsu_rsp_q <= lsu_rsp_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.ifu_req_ready = grant_ifu;
  assign bus.lsu_req_ready = grant_lsu;
  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_wen       = wen_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.ifu_rsp_valid = ifu_rsp_q;
  assign bus.lsu_rsp_valid = lsu_rsp_q;
  assign bus.ifu_rdata     = ifu_rsp_q ? rdata_q : 32'd0;
  assign bus.lsu_rdata     = lsu_rsp_q ? rdata_q : 32'd0;
  assign bus.rsp_err       = err_q;
  assign bus.bus_err       = bus_err_q;
endmodule

// File: tb/tb_ifu_lsu_arbiter.sv
// Directed bench for ifu_lsu_arbiter: single requests, contention, starvation limit,
// response timeout and reset during an outstanding transaction.
module tb_ifu_lsu_arbiter;
  logic clk;
  logic rst;
  logic auto_rsp;
  logic force_rsp;
  int   n_chk;
  int   n_err;

  ifu_lsu_arbiter_if bus();

  ifu_lsu_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: always ready, answers the cycle after the handshake with addr ^ 0x80100073.
  initial begin
    logic        hs;
    logic [31:0] a;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      hs = bus.mem_req_valid && bus.mem_req_ready;
      a  = bus.mem_addr;
      #1;
      bus.mem_rsp_valid = (hs && auto_rsp) || force_rsp;
      bus.mem_rdata     = (hs || force_rsp) ? (a ^ 32'h80100073) : 32'hDEADBEEF;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic g [10];
    int   ng;
    n_chk     = 0;
    n_err     = 0;
    auto_rsp  = 1'b1;
    force_rsp = 1'b0;
    rst = 1'b1;
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_req_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    check_eq("rst_lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
    check_eq("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    check_eq("rst_ifu_rsp",   32'(bus.ifu_rsp_valid), 32'd0);
    check_eq("rst_lsu_rsp",   32'(bus.lsu_rsp_valid), 32'd0);
    check_eq("rst_rsp_err",   32'(bus.rsp_err),       32'd0);
    check_eq("rst_bus_err",   32'(bus.bus_err),       32'd0);
    check_eq("rst_mem_addr",  bus.mem_addr,           32'd0);
    check_eq("rst_mem_wen",   32'(bus.mem_wen),       32'd0);
    check_eq("rst_mem_wmask", 32'(bus.mem_wmask),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // IFU alone
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h80000000;
    @(negedge clk);
    check_eq("t1_ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
    check_eq("t1_lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
    check_eq("t1_c0_memv",   32'(bus.mem_req_valid), 32'd0);
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_c1_memv",  32'(bus.mem_req_valid), 32'd1);
    check_eq("t1_c1_addr",  bus.mem_addr,           32'h80000000);
    check_eq("t1_c1_wen",   32'(bus.mem_wen),       32'd0);
    check_eq("t1_c1_wmask", 32'(bus.mem_wmask),     32'd0);
    @(negedge clk);
    check_eq("t1_c2_memv",  32'(bus.mem_req_valid), 32'd0);
    check_eq("t1_c2_rsp",   32'(bus.ifu_rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_c3_rsp",   32'(bus.ifu_rsp_valid), 32'd1);
    check_eq("t1_c3_rdata", bus.ifu_rdata,          32'h00100073);
    check_eq("t1_c3_err",   32'(bus.rsp_err),       32'd0);
    check_eq("t1_c3_lsu",   32'(bus.lsu_rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_c4_rsp",   32'(bus.ifu_rsp_valid), 32'd0);

    // LSU write
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b1;
    bus.lsu_addr      = 32'h80001000;
    bus.lsu_wdata     = 32'hA5A5A5A5;
    bus.lsu_wmask     = 4'b0011;
    @(negedge clk);
    check_eq("t2_lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    check_eq("t2_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_memv",  32'(bus.mem_req_valid), 32'd1);
    check_eq("t2_wen",   32'(bus.mem_wen),       32'd1);
    check_eq("t2_addr",  bus.mem_addr,           32'h80001000);
    check_eq("t2_wdata", bus.mem_wdata,          32'hA5A5A5A5);
    check_eq("t2_wmask", 32'(bus.mem_wmask),     32'h3);
    @(negedge clk);
    @(negedge clk);
    check_eq("t2_rsp",     32'(bus.lsu_rsp_valid), 32'd1);
    check_eq("t2_rdata",   bus.lsu_rdata,          32'd0);
    check_eq("t2_ifu_rsp", 32'(bus.ifu_rsp_valid), 32'd0);
    check_eq("t2_err",     32'(bus.rsp_err),       32'd0);

    // Contention with streak 0
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h80000004;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b0;
    bus.lsu_addr      = 32'h80002000;
    @(negedge clk);
    check_eq("t3_lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    check_eq("t3_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    @(negedge clk);
    check_eq("t3_addr_lsu", bus.mem_addr,           32'h80002000);
    check_eq("t3_ifu_busy", 32'(bus.ifu_req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("t3_lsu_rsp",   32'(bus.lsu_rsp_valid), 32'd1);
    check_eq("t3_lsu_rdata", bus.lsu_rdata,          32'h00102073);
    check_eq("t3_ifu_rsp0",  32'(bus.ifu_rsp_valid), 32'd0);
    check_eq("t3_ifu_grant", 32'(bus.ifu_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    check_eq("t3_addr_ifu", bus.mem_addr, 32'h80000004);
    @(negedge clk);
    @(negedge clk);
    check_eq("t3_ifu_rsp",   32'(bus.ifu_rsp_valid), 32'd1);
    check_eq("t3_ifu_rdata", bus.ifu_rdata,          32'h00100077);
    check_eq("t3_lsu_rsp0",  32'(bus.lsu_rsp_valid), 32'd0);

    // Starvation: both valid continuously
    @(posedge clk); #1;
    ng = 0;
    bus.ifu_addr      = 32'h80000100;
    bus.lsu_addr      = 32'h80004000;
    bus.lsu_wen       = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    for (int k = 0; k < 80 && ng < 10; k++) begin
      @(negedge clk);
      if (bus.ifu_req_ready) begin
        g[ng] = 1'b1;
        ng++;
      end else if (bus.lsu_req_ready) begin
        g[ng] = 1'b0;
        ng++;
      end
    end
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    check_eq("t4_grant_count", 32'(ng), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < ng) check_eq($sformatf("t4_grant%0d_is_ifu", i), 32'(g[i]), (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    repeat (4) @(negedge clk);

    // Timeout with a silent memory
    @(posedge clk); #1;
    auto_rsp          = 1'b0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b0;
    bus.lsu_addr      = 32'h80003000;
    @(negedge clk);
    check_eq("t5_lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("t5_c9_rsp",     32'(bus.lsu_rsp_valid), 32'd0);
    check_eq("t5_c9_bus_err", 32'(bus.bus_err),       32'd0);
    @(negedge clk);
    check_eq("t5_c10_rsp",     32'(bus.lsu_rsp_valid), 32'd1);
    check_eq("t5_c10_rdata",   bus.lsu_rdata,          32'd0);
    check_eq("t5_c10_rsp_err", 32'(bus.rsp_err),       32'd1);
    check_eq("t5_c10_bus_err", 32'(bus.bus_err),       32'd1);
    check_eq("t5_c10_ifu_rsp", 32'(bus.ifu_rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("t5_c11_rsp",     32'(bus.lsu_rsp_valid), 32'd0);
    check_eq("t5_c11_rsp_err", 32'(bus.rsp_err),       32'd0);
    check_eq("t5_c11_bus_err", 32'(bus.bus_err),       32'd1);

    // bus_err stays set across a later good transaction
    @(posedge clk); #1;
    auto_rsp          = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h80000008;
    @(negedge clk);
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5b_rsp",     32'(bus.ifu_rsp_valid), 32'd1);
    check_eq("t5b_rdata",   bus.ifu_rdata,          32'h0010007B);
    check_eq("t5b_rsp_err", 32'(bus.rsp_err),       32'd0);
    check_eq("t5b_bus_err", 32'(bus.bus_err),       32'd1);

    // Reset while waiting for memory
    @(posedge clk); #1;
    auto_rsp          = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h80000010;
    @(negedge clk);
    check_eq("t6_ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_ifu_rsp",  32'(bus.ifu_rsp_valid), 32'd0);
    check_eq("t6_lsu_rsp",  32'(bus.lsu_rsp_valid), 32'd0);
    check_eq("t6_memv",     32'(bus.mem_req_valid), 32'd0);
    check_eq("t6_bus_err",  32'(bus.bus_err),       32'd0);
    check_eq("t6_rsp_err",  32'(bus.rsp_err),       32'd0);
    check_eq("t6_mem_addr", bus.mem_addr,           32'd0);
    check_eq("t6_rdata",    bus.ifu_rdata,          32'd0);
    force_rsp = 1'b1;
    @(negedge clk);
    force_rsp = 1'b0;
    check_eq("t6_stray_c5", 32'(bus.ifu_rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("t6_stray_ifu", 32'(bus.ifu_rsp_valid), 32'd0);
    check_eq("t6_stray_lsu", 32'(bus.lsu_rsp_valid), 32'd0);
    check_eq("t6_stray_memv", 32'(bus.mem_req_valid), 32'd0);
    @(posedge clk); #1;
    auto_rsp          = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h80000020;
    @(negedge clk);
    check_eq("t6_new_ready", 32'(bus.ifu_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_new_memv", 32'(bus.mem_req_valid), 32'd1);
    check_eq("t6_new_addr", bus.mem_addr,           32'h80000020);
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_new_rsp",   32'(bus.ifu_rsp_valid), 32'd1);
    check_eq("t6_new_rdata", bus.ifu_rdata,          32'h00100053);
    check_eq("t6_new_err",   32'(bus.rsp_err),       32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
